// File: rtl/lowp_pkg.sv
// Shared definitions for the lowpass chain: sample width, fractional extension
// and decimation limits used by the front-end averager and the IIR stages.
package lowp_pkg;

   localparam int SAMPLE_W = 28;
   localparam int FRAC_EXT = 4;
   localparam int MAX_LOG2 = 6;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // Requested decimation exponent limited to what the accumulator can hold.
   function automatic logic [2:0] clamp_k(input logic [2:0] k, input int max_k);
      return (int'(k) > max_k) ? 3'(max_k) : k;
   endfunction

endpackage

// File: rtl/decim_strobe_if.sv
// Sample bus between the demodulator front end (master) and the decimating
// averager (slave): raw samples in, averaged samples plus filter strobe out.
interface decim_strobe_if #(
   parameter int IN_W     = 24,
   parameter int OUT_W    = lowp_pkg::SAMPLE_W,
   parameter int MAX_LOG2 = lowp_pkg::MAX_LOG2
);
   import lowp_pkg::*;

   logic signed [IN_W-1:0]  signal_in;
   logic                    in_valid;
   logic                    sync;
   logic [2:0]              log2_ratio;
   logic signed [OUT_W-1:0] signal_out;
   logic                    enable;
   logic [MAX_LOG2-1:0]     frame_pos;

   modport master (
      output signal_in, in_valid, sync, log2_ratio,
      input  signal_out, enable, frame_pos
   );

   modport slave (
      input  signal_in, in_valid, sync, log2_ratio,
      output signal_out, enable, frame_pos
   );

endinterface

// File: rtl/decim_round_shift.sv
// Scales a frame total to the output format: append fractional bits, then divide
// by 2^k. Define DECIM_ROUND_EN for round-half-up instead of floor truncation.
module decim_round_shift #(
   parameter int ACC_W  = 30,
   parameter int OUT_W  = lowp_pkg::SAMPLE_W,
   parameter int FRAC_W = lowp_pkg::FRAC_EXT,
   parameter int K_W    = 3
) (
   input  logic signed [ACC_W-1:0] total,
   input  logic [K_W-1:0]          k,
   output logic signed [OUT_W-1:0] scaled
);
   import lowp_pkg::*;

   // One spare bit above the shifted total so the rounding bias cannot overflow.
   localparam int EXT_W = ACC_W + FRAC_W + 1;

   logic signed [EXT_W-1:0] ext;
   logic signed [EXT_W-1:0] biased;
   logic signed [EXT_W-1:0] shifted;

   always_comb begin
      ext = EXT_W'(total) <<< FRAC_W;
`ifdef DECIM_ROUND_EN
      biased = ext;
      if (k != '0) begin
         biased = ext + (EXT_W'(1) << (k - K_W'(1)));
      end
`else
      biased = ext;
`endif
      shifted = biased >>> k;
      scaled  = OUT_W'(shifted);
   end

endmodule

// File: rtl/decim_strobe.sv
// Decimating boxcar averager: sums 2^k valid samples and emits the scaled mean
// with a one-cycle enable strobe. Optional rounding via DECIM_ROUND_EN.
module decim_strobe #(
   parameter int IN_W     = 24,
   parameter int OUT_W    = lowp_pkg::SAMPLE_W,
   parameter int MAX_LOG2 = lowp_pkg::MAX_LOG2
) (
   input  logic           clock_in,
   input  logic           reset,
   decim_strobe_if.slave  bus
);
   import lowp_pkg::*;

   localparam int ACC_W = IN_W + MAX_LOG2;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_base;
   logic signed [ACC_W-1:0] total;
   logic [MAX_LOG2-1:0]     frame_pos;
   logic [MAX_LOG2-1:0]     pos_base;
   logic [MAX_LOG2-1:0]     last_pos;
   logic [2:0]              k_r;
   logic [2:0]              k_in;
   logic [2:0]              k_eff;
   logic                    frame_done;
   logic signed [OUT_W-1:0] scaled;
   logic signed [OUT_W-1:0] signal_out_r;
   logic                    enable_r;

   // sync behaves as if the frame were already empty, so a coincident sample
   // starts the new frame with the freshly requested ratio.
   always_comb begin
      k_in       = clamp_k(bus.log2_ratio, MAX_LOG2);
      pos_base   = bus.sync ? '0 : frame_pos;
      acc_base   = bus.sync ? '0 : acc;
      k_eff      = (pos_base == '0) ? k_in : k_r;
      last_pos   = MAX_LOG2'((1 << k_eff) - 1);
      total      = acc_base + ACC_W'(bus.signal_in);
      frame_done = (pos_base == last_pos);
   end

   decim_round_shift #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .FRAC_W(OUT_W - IN_W),
      .K_W   (3)
   ) u_scale (
      .total (total),
      .k     (k_eff),
      .scaled(scaled)
   );

   always_ff @(posedge clock_in) begin
      if (reset) begin
         acc          <= '0;
         frame_pos    <= '0;
         k_r          <= k_in;
         signal_out_r <= '0;
         enable_r     <= 1'b0;
      end else begin
         enable_r <= 1'b0;
         if (bus.in_valid) begin
            k_r <= k_eff;
            if (frame_done) begin
               signal_out_r <= scaled;
               enable_r     <= 1'b1;
               acc          <= '0;
               frame_pos    <= '0;
            end else begin
               acc       <= total;
               frame_pos <= pos_base + MAX_LOG2'(1);
            end
         end else if (bus.sync) begin
            acc       <= '0;
            frame_pos <= '0;
            k_r       <= k_in;
         end
      end
   end

   assign bus.signal_out = signal_out_r;
   assign bus.enable     = enable_r;
   assign bus.frame_pos  = frame_pos;

endmodule

// File: tb/tb_decim_strobe.sv
// Scoreboard bench for decim_strobe: a sample-list reference model predicts each
// averaged output; a negedge monitor checks strobes, held output and frame_pos.
module tb_decim_strobe;
   import lowp_pkg::*;

   localparam int IN_W = 24;

   logic clock_in;
   logic reset;

   decim_strobe_if #(.IN_W(IN_W), .OUT_W(SAMPLE_W), .MAX_LOG2(MAX_LOG2)) bus ();

   decim_strobe dut (
      .clock_in(clock_in),
      .reset   (reset),
      .bus     (bus)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   // Reference model state: the samples of the current frame, the frame ratio,
   // the value signal_out should be holding and the queue of pending strobes.
   longint  frame_q[$];
   int      m_k;
   sample_t hold;
   int      exp_pos;
   sample_t exp_q[$];

   task automatic chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic longint floor_div(input longint num, input longint d);
      longint q;
      q = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint mean_scaled(input longint sum, input int k);
      longint num;
      longint d;
      num = sum * 16;
      d   = longint'(1) << k;
`ifdef DECIM_ROUND_EN
      if (k > 0) num = num + d / 2;
`endif
      return floor_div(num, d);
   endfunction

   function automatic int clamp_ref(input logic [2:0] lr);
      return (int'(lr) > 6) ? 6 : int'(lr);
   endfunction

   task automatic model(input bit v, input bit s, input logic [2:0] lr,
                        input logic signed [IN_W-1:0] d, input bit r);
      longint sum;
      if (r) begin
         frame_q.delete();
         exp_q.delete();
         m_k  = clamp_ref(lr);
         hold = '0;
      end else begin
         if (s) begin
            frame_q.delete();
            m_k = clamp_ref(lr);
         end
         if (v) begin
            if (frame_q.size() == 0) m_k = clamp_ref(lr);
            frame_q.push_back(longint'(d));
            if (frame_q.size() == (1 << m_k)) begin
               sum = 0;
               foreach (frame_q[i]) sum += frame_q[i];
               hold = sample_t'(mean_scaled(sum, m_k));
               exp_q.push_back(hold);
               frame_q.delete();
            end
         end
      end
      exp_pos = frame_q.size();
   endtask

   task automatic step(input bit v, input bit s, input logic [2:0] lr,
                       input logic signed [IN_W-1:0] d, input bit r = 1'b0);
      bus.in_valid   = v;
      bus.sync       = s;
      bus.log2_ratio = lr;
      bus.signal_in  = d;
      reset          = r;
      @(posedge clock_in);
      model(v, s, lr, d, r);
      #1;
   endtask

   always @(negedge clock_in) begin
      if (mon_en) begin
         bit      exp_en;
         sample_t e;
         exp_en = (exp_q.size() != 0);
         chk("enable", longint'(bus.enable), longint'(exp_en));
         if (exp_en) begin
            e = exp_q.pop_front();
            if (bus.enable) chk("strobe_value", longint'(bus.signal_out), longint'(e));
         end
         chk("signal_out_hold", longint'(bus.signal_out), longint'(hold));
         chk("frame_pos", longint'(bus.frame_pos), longint'(exp_pos));
      end
   end

   initial begin
      logic signed [IN_W-1:0] d;
      logic [2:0] lr;
      bit v, s, r;

      bus.in_valid = 1'b0;
      bus.sync = 1'b0;
      bus.log2_ratio = 3'd2;
      bus.signal_in = '0;
      reset = 1'b1;
      step(0, 0, 3'd2, 0, 1);
      step(0, 0, 3'd2, 0, 1);
      mon_en = 1'b1;
      chk("reset_out", longint'(bus.signal_out), 0);
      chk("reset_en", longint'(bus.enable), 0);
      chk("reset_pos", longint'(bus.frame_pos), 0);

      // k=2 basic frame
      step(1, 0, 3'd2, 100);  chk("tp1_pos1", longint'(bus.frame_pos), 1);
      step(1, 0, 3'd2, 200);  chk("tp1_pos2", longint'(bus.frame_pos), 2);
      step(1, 0, 3'd2, 300);  chk("tp1_pos3", longint'(bus.frame_pos), 3);
      step(1, 0, 3'd2, 400);
      chk("tp1_pos0", longint'(bus.frame_pos), 0);
      chk("tp1_en", longint'(bus.enable), 1);
      chk("tp1_out", longint'(bus.signal_out), 4000);
      step(0, 0, 3'd2, 0);
      step(0, 0, 3'd2, 0);
      chk("tp1_held", longint'(bus.signal_out), 4000);
      chk("tp1_en_low", longint'(bus.enable), 0);

      // k=6 rounding boundary, sum = 2 then sum = -1
      step(1, 0, 3'd6, 1);
      step(1, 0, 3'd6, 1);
      for (int i = 0; i < 62; i++) step(1, 0, 3'd6, (i % 2 == 0) ? 1000 : -1000);
`ifdef DECIM_ROUND_EN
      chk("k6_sum2", longint'(bus.signal_out), 1);
`else
      chk("k6_sum2", longint'(bus.signal_out), 0);
`endif
      step(1, 0, 3'd6, -1);
      step(1, 0, 3'd6, 0);
      for (int i = 0; i < 62; i++) step(1, 0, 3'd6, (i % 2 == 0) ? 500 : -500);
`ifdef DECIM_ROUND_EN
      chk("k6_sum_m1", longint'(bus.signal_out), 0);
`else
      chk("k6_sum_m1", longint'(bus.signal_out), -1);
`endif

      // k=0 full-scale pass-through
      step(1, 0, 3'd0, 24'sd8388607);
      chk("k0_en_a", longint'(bus.enable), 1);
      chk("k0_max", longint'(bus.signal_out), 134217712);
      step(1, 0, 3'd0, -24'sd8388608);
      chk("k0_en_b", longint'(bus.enable), 1);
      chk("k0_min", longint'(bus.signal_out), -134217728);

      // sync restarts a k=3 frame
      for (int i = 0; i < 5; i++) step(1, 0, 3'd3, 9);
      step(1, 1, 3'd3, 50);
      chk("sync_pos", longint'(bus.frame_pos), 1);
      for (int i = 0; i < 7; i++) step(1, 0, 3'd3, 50);
      chk("sync_en", longint'(bus.enable), 1);
      chk("sync_out", longint'(bus.signal_out), 800);

      // ratio change mid-frame applies only to the next frame
      step(1, 0, 3'd2, 4);
      step(1, 0, 3'd2, 8);
      step(1, 0, 3'd1, 12);
      chk("ratio_mid_en", longint'(bus.enable), 0);
      step(1, 0, 3'd1, 16);
      chk("ratio_old_en", longint'(bus.enable), 1);
      chk("ratio_old_out", longint'(bus.signal_out), 160);
      step(1, 0, 3'd1, 3);
      step(1, 0, 3'd1, 5);
      chk("ratio_new_en", longint'(bus.enable), 1);
      chk("ratio_new_out", longint'(bus.signal_out), 64);

      // reset mid-frame drops the partial sum
      step(1, 0, 3'd2, 100);
      step(1, 0, 3'd2, 200);
      step(1, 0, 3'd2, 300);
      step(1, 0, 3'd2, 400);
      step(1, 0, 3'd2, 1000);
      step(1, 0, 3'd2, 1000);
      chk("pre_rst_out", longint'(bus.signal_out), 4000);
      step(0, 0, 3'd2, 0, 1);
      chk("rst_out", longint'(bus.signal_out), 0);
      chk("rst_en", longint'(bus.enable), 0);
      chk("rst_pos", longint'(bus.frame_pos), 0);
      step(1, 0, 3'd2, 10);
      step(1, 0, 3'd2, 20);
      step(1, 0, 3'd2, 30);
      step(1, 0, 3'd2, 40);
      chk("post_rst_out", longint'(bus.signal_out), 400);

      // randomized traffic against the model
      lr = 3'd2;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 8) lr = 3'($urandom_range(0, 7));
         v = ($urandom_range(0, 99) < 75);
         s = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 999) < 4);
         d = IN_W'($urandom);
         step(v, s, lr, d, r);
      end

      step(0, 0, lr, 0);
      @(negedge clock_in);
      #1;
      chk("drained", longint'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decim_strobe.md
# decim_strobe

Decimating boxcar averager that feeds the 28-bit signed IIR lowpass stages. It accepts narrower raw samples with a valid qualifier and averages 2^k consecutive samples. Each result is presented as a 28-bit sample with 4 added fractional bits, together with the one-cycle `enable` strobe the filter consumes. It sits between the ADC/demodulator front end and the lowpass chain, setting the filter sample rate.

## Interface

- `IN_W`, 24: input sample width (signed).
- `OUT_W`, 28: output sample width; `OUT_W - IN_W` = 4 fractional bits added.
- `MAX_LOG2`, 6: maximum decimation exponent; ratio R = 2^k, k ≤ MAX_LOG2.

Ports:

- `clock_in` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `signal_in` in IN_W: signed input sample.
- `in_valid` in 1: `signal_in` is consumed this cycle.
- `sync` in 1: frame restart; discards the partial sum.
- `log2_ratio` in 3: k; values above MAX_LOG2 are clamped to MAX_LOG2.
- `signal_out` out OUT_W: signed averaged sample, held between strobes.
- `enable` out 1: one-cycle strobe; `signal_out` is new this cycle.
- `frame_pos` out MAX_LOG2: count of samples accumulated in the current frame.

## Operation

- Accumulator width is IN_W+MAX_LOG2 (30 bits), signed, so it cannot overflow.
- Sample counter `frame_pos` runs from 0 to R-1.
- The ratio is latched into `k_r` whenever a frame starts (`frame_pos`==0 and `in_valid`), and also on reset and on `sync`.
  - Changing `log2_ratio` mid-frame has no effect until the next frame.
- On `in_valid` with `frame_pos` < R-1: acc += `signal_in`; `frame_pos` += 1.
- On `in_valid` with `frame_pos` == R-1 (frame completes):
  - Compute total = acc + `signal_in`.
  - `signal_out` <= (total <<< 4) >>> `k_r`, taking the low OUT_W bits. The result always fits; no saturation logic is needed.
  - `enable` <= 1; acc <= 0; `frame_pos` <= 0.
- k = 0 is pass-through: every valid sample produces `signal_out` = `signal_in` <<< 4 and a strobe.
- `sync` takes priority over the normal update:
  - acc and `frame_pos` are cleared and `k_r` is reloaded from `log2_ratio`.
  - If `in_valid` is also high, that sample becomes sample 0 of the new frame (acc = `signal_in`, `frame_pos` = 1, or an immediate strobe when k = 0).
  - `sync` never produces a strobe on its own.
- Reset has priority over everything else.
  - Values after reset: `signal_out` = 0, `enable` = 0, `frame_pos` = 0, acc = 0, `k_r` = clamped `log2_ratio`.
  - A reset during a frame discards the partial sum.
- When `in_valid` is low, state holds and `enable` is 0.

## Timing

- Latency: `enable` and the new `signal_out` appear in the cycle after the clock edge that samples the R-th valid sample (registered outputs, 1 cycle).
- `enable` is high for exactly one cycle per frame.
  - Back-to-back strobes are possible only when k = 0 and `in_valid` is continuously high.
- `signal_out` changes only in cycles where `enable` is high, or on reset.
- `in_valid` is accepted every cycle; the block never stalls and has no backpressure.

## Configuration

- `DECIM_ROUND_EN` defined: round half up.
  - Adds 2^(k-1) to (total <<< 4) before the arithmetic shift when k > 0.
  - The sum is formed at accumulator width + 5 bits so the addition cannot overflow.
- Not defined: plain arithmetic-shift truncation toward −∞; no adder.
- k = 0 output is identical in both builds.

## Structure

- Shared package `lowp_pkg` holds:
  - `SAMPLE_W` = 28, matching the filter sample width.
  - `FRAC_EXT` = 4.
  - `MAX_LOG2` = 6.
  - The typedef `sample_t` (signed [SAMPLE_W-1:0]).
- One sub-module, `decim_round_shift`: combinational scaling of total by (<<< 4, optional round, >>> k) to OUT_W.
  - Keeps the `DECIM_ROUND_EN` conditional local to that sub-module.
- Counter, accumulator, ratio latch and strobe register live in the top module.

## Test plan

- After reset: k=2, `in_valid` high with inputs 100, 200, 300, 400.
  - Required: one `enable` pulse one cycle after the 400 is sampled, with `signal_out` = 4000, then held.
  - `frame_pos` steps 1, 2, 3, 0.
- k=6, 64 samples summing to 2: output 0 without `DECIM_ROUND_EN`, 1 with it.
  - With sum −1: output −1 truncated, 0 rounded.
- k=0, full-scale inputs 8388607 then −8388608 on consecutive cycles.
  - Required: strobes on 2 consecutive cycles, outputs 134217712 and −134217728.
- k=3: after 5 valid samples, pulse `sync` together with a valid sample of 50, then send 7 more samples of 50.
  - Required: no strobe from the partial frame; exactly one strobe, with `signal_out` = 800.
- k=2 frame in progress (`frame_pos`=2), change `log2_ratio` to 1.
  - Required: the current frame still completes after 4 samples; the next frame strobes after 2.
- Assert `reset` mid-frame with `signal_out` = 4000.
  - Required: next cycle `signal_out` = 0, `enable` = 0, `frame_pos` = 0; no stale partial sum is included in the following frame.
